// File: rtl/counter_4b_modes.sv
// Modulo-2^WIDTH counter with +1 / -1 / +3 / load modes.
// RCO flags the cycle after a wrap; VALID sets on the first update after reset.
module counter_4b_modes #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENB,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             VALID
);

  localparam int unsigned SUM_W = WIDTH + 1;

  localparam logic [1:0] MODE_INC  = 2'b00;
  localparam logic [1:0] MODE_DEC  = 2'b01;
  localparam logic [1:0] MODE_INC3 = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             rco_q, rco_d;
  logic             valid_q, valid_d;
  logic [WIDTH:0]   sum_c;

  // Extended arithmetic: the top bit of sum_c is the carry or borrow out.
  always_comb begin
    cnt_d   = cnt_q;
    rco_d   = 1'b0;
    valid_d = valid_q;
    sum_c   = {1'b0, cnt_q};
    if (ENB) begin
      valid_d = 1'b1;
      case (MODE)
        MODE_INC: begin
          sum_c = {1'b0, cnt_q} + SUM_W'(1);
          cnt_d = sum_c[WIDTH-1:0];
          rco_d = sum_c[WIDTH];
        end
        MODE_DEC: begin
          sum_c = {1'b0, cnt_q} - SUM_W'(1);
          cnt_d = sum_c[WIDTH-1:0];
          rco_d = sum_c[WIDTH];
        end
        MODE_INC3: begin
          sum_c = {1'b0, cnt_q} + SUM_W'(3);
          cnt_d = sum_c[WIDTH-1:0];
          rco_d = sum_c[WIDTH];
        end
        MODE_LOAD: begin
          cnt_d = D;
          rco_d = 1'b0;
        end
        default: begin
          cnt_d = cnt_q;
          rco_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q   <= '0;
      rco_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rco_q   <= rco_d;
      valid_q <= valid_d;
    end
  end

  assign Q     = cnt_q;
  assign RCO   = rco_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_counter_4b_modes.sv
// Directed bench for counter_4b_modes: a 4-bit and an 8-bit instance,
// inputs driven on the falling edge, outputs checked on the falling edge.
module tb_counter_4b_modes;

  logic       CLK;
  logic       RESET_N;
  logic       ENB;
  logic [1:0] MODE;
  logic [3:0] D;
  logic [3:0] Q;
  logic       RCO;
  logic       VALID;

  logic       enb8;
  logic [1:0] mode8;
  logic [7:0] d8;
  logic [7:0] q8;
  logic       rco8;
  logic       valid8;

  int checks;
  int failures;

  counter_4b_modes #(.WIDTH(4)) u_dut4 (
    .CLK(CLK), .RESET_N(RESET_N), .ENB(ENB), .MODE(MODE), .D(D),
    .Q(Q), .RCO(RCO), .VALID(VALID)
  );

  counter_4b_modes #(.WIDTH(8)) u_dut8 (
    .CLK(CLK), .RESET_N(RESET_N), .ENB(enb8), .MODE(mode8), .D(d8),
    .Q(q8), .RCO(rco8), .VALID(valid8)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, let the rising edge update, return at the next falling edge.
  task automatic step(input logic enb, input logic [1:0] mode, input logic [3:0] d);
    ENB  = enb;
    MODE = mode;
    D    = d;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk3(input string tag, input logic [3:0] q_exp, input logic rco_exp, input logic valid_exp);
    chk({tag, "_q"}, 32'(Q), 32'(q_exp));
    chk({tag, "_rco"}, 32'(RCO), 32'(rco_exp));
    chk({tag, "_valid"}, 32'(VALID), 32'(valid_exp));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET_N  = 1'b0;
    ENB      = 1'b0;
    MODE     = 2'b00;
    D        = 4'h0;
    enb8     = 1'b0;
    mode8    = 2'b00;
    d8       = 8'h00;

    @(negedge CLK);
    @(negedge CLK);
    chk3("reset", 4'h0, 1'b0, 1'b0);
    RESET_N = 1'b1;

    // Disabled edge after release keeps VALID low
    step(1'b0, 2'b00, 4'h0);
    chk3("idle_after_rst", 4'h0, 1'b0, 1'b0);

    // 1: reset asserted mid-cycle clears without a clock edge
    step(1'b1, 2'b11, 4'h3);
    chk3("load3", 4'h3, 1'b0, 1'b1);
    ENB  = 1'b1;
    MODE = 2'b00;
    #2 RESET_N = 1'b0;
    #1 chk3("async_rst", 4'h0, 1'b0, 1'b0);
    @(negedge CLK);
    chk3("rst_held", 4'h0, 1'b0, 1'b0);
    RESET_N = 1'b1;
    step(1'b1, 2'b00, 4'h0);
    chk3("first_inc", 4'h1, 1'b0, 1'b1);

    // 2: up wrap
    step(1'b1, 2'b11, 4'hE);
    chk3("load_e", 4'hE, 1'b0, 1'b1);
    step(1'b1, 2'b00, 4'h0);
    chk3("inc_f", 4'hF, 1'b0, 1'b1);
    step(1'b1, 2'b00, 4'h0);
    chk3("inc_wrap", 4'h0, 1'b1, 1'b1);
    step(1'b0, 2'b00, 4'h0);
    chk3("inc_wrap_clr", 4'h0, 1'b0, 1'b1);

    // 3: down wrap
    step(1'b1, 2'b11, 4'h1);
    step(1'b1, 2'b01, 4'h0);
    chk3("dec_0", 4'h0, 1'b0, 1'b1);
    step(1'b1, 2'b01, 4'h0);
    chk3("dec_wrap", 4'hF, 1'b1, 1'b1);
    step(1'b1, 2'b01, 4'h0);
    chk3("dec_e", 4'hE, 1'b0, 1'b1);

    // 4: step by 3, including back-to-back wraps across a load
    step(1'b1, 2'b11, 4'hC);
    step(1'b1, 2'b10, 4'h0);
    chk3("inc3_f", 4'hF, 1'b0, 1'b1);
    step(1'b1, 2'b10, 4'h0);
    chk3("inc3_wrap", 4'h2, 1'b1, 1'b1);
    step(1'b1, 2'b11, 4'hD);
    chk3("load_d", 4'hD, 1'b0, 1'b1);
    step(1'b1, 2'b10, 4'h0);
    chk3("inc3_wrap0", 4'h0, 1'b1, 1'b1);
    step(1'b1, 2'b10, 4'h0);
    chk3("inc3_3", 4'h3, 1'b0, 1'b1);

    // 5: hold with ENB low
    step(1'b1, 2'b11, 4'h7);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 4'h0);
      chk3("hold", 4'h7, 1'b0, 1'b1);
    end

    // 6: load from all-ones does not flag a wrap
    step(1'b1, 2'b11, 4'hF);
    step(1'b1, 2'b11, 4'hA);
    chk3("load_over_wrap", 4'hA, 1'b0, 1'b1);

    // 6b: 8-bit instance, +3 wrap from 0xFE and +1 wrap from 0xFF
    chk("w8_valid_idle", 32'(valid8), 32'd0);
    enb8  = 1'b1;
    mode8 = 2'b11;
    d8    = 8'hFE;
    @(posedge CLK);
    @(negedge CLK);
    chk("w8_load_q", 32'(q8), 32'hFE);
    mode8 = 2'b10;
    @(posedge CLK);
    @(negedge CLK);
    chk("w8_inc3_q", 32'(q8), 32'h01);
    chk("w8_inc3_rco", 32'(rco8), 32'd1);
    chk("w8_valid", 32'(valid8), 32'd1);
    mode8 = 2'b11;
    d8    = 8'hFF;
    @(posedge CLK);
    @(negedge CLK);
    chk("w8_load_rco", 32'(rco8), 32'd0);
    mode8 = 2'b00;
    @(posedge CLK);
    @(negedge CLK);
    chk("w8_inc_q", 32'(q8), 32'h00);
    chk("w8_inc_rco", 32'(rco8), 32'd1);
    enb8 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
